// File: rtl/reorder_buffer_pkg.sv
// Reorder buffer shared types.
// CDB bundle, per-entry state and sizing.
package reorder_buffer_pkg;

  localparam int ROB_TAG_W = 3;
  localparam int ROB_DEPTH = 2 ** ROB_TAG_W;

  typedef logic [15:0] lc3b_word;
  typedef logic [2:0]  lc3b_reg;
  typedef logic [ROB_TAG_W-1:0] rob_tag_t;

  typedef struct packed {
    logic     valid;
    rob_tag_t tag;
    lc3b_word data;
  } cdb_t;

  typedef struct packed {
    logic     valid;
    logic     ready;
    logic     has_dest;
    lc3b_reg  dest_reg;
    lc3b_word value;
  } rob_entry_t;

  function automatic rob_tag_t tag_inc(input rob_tag_t t);
    return t + 1'b1;
  endfunction

endpackage

// File: rtl/reorder_buffer_entry.sv
// One reorder buffer slot.
// Allocated empty, filled by CDB, cleared on retire.
module rob_entry
  import reorder_buffer_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       alloc,
  input  logic       has_dest,
  input  lc3b_reg    dest_reg,
  input  logic       cdb_wr,
  input  lc3b_word   cdb_data,
  input  logic       clear,
  output rob_entry_t q
);

  // slot state: reset/flush, then alloc, retire, CDB fill
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      q <= '0;
    end else if (alloc) begin
      q <= '{valid: 1'b1, ready: 1'b0,
             has_dest: has_dest,
             dest_reg: dest_reg,
             value: '0};
    end else if (clear) begin
      q.valid <= 1'b0;
      q.ready <= 1'b0;
    end else if (cdb_wr && q.valid) begin
      q.ready <= 1'b1;
      q.value <= cdb_data;
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// In-order commit queue with CDB fill.
// Two lookup ports forward uncommitted values.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int data_width = 16,
  parameter int tag_width  = ROB_TAG_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  cdb_t                  CDB_in,
  input  logic                  alloc_req,
  input  logic                  alloc_has_dest,
  input  lc3b_reg               alloc_dest_reg,
  output logic [tag_width-1:0]  alloc_tag,
  output logic                  full,
  output logic                  empty,
  input  logic [tag_width-1:0]  lookup_tag_a,
  output logic                  lookup_rdy_a,
  output logic [data_width-1:0] lookup_val_a,
  input  logic [tag_width-1:0]  lookup_tag_b,
  output logic                  lookup_rdy_b,
  output logic [data_width-1:0] lookup_val_b,
  output logic                  commit_valid,
  output logic                  commit_we,
  output lc3b_reg               commit_reg,
  output logic [data_width-1:0] commit_data,
  output logic [tag_width-1:0]  commit_tag
);

  localparam logic [tag_width:0] DEPTH_C =
    (tag_width+1)'(ROB_DEPTH);

  rob_entry_t ent [ROB_DEPTH];
  rob_entry_t head_e;
  rob_tag_t   head;
  rob_tag_t   tail;
  logic [tag_width:0] count;
  logic [tag_width:0] count_nxt;
  logic       alloc_ok;

  assign full     = (count == DEPTH_C);
  assign empty    = (count == '0);
  assign alloc_ok = alloc_req & ~full;
  assign alloc_tag = tail;

  for (genvar i = 0; i < ROB_DEPTH; i++) begin : g_ent
    rob_entry u_ent (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .alloc    (alloc_ok && tail == rob_tag_t'(i)),
      .has_dest (alloc_has_dest),
      .dest_reg (alloc_dest_reg),
      .cdb_wr   (CDB_in.valid &&
                 CDB_in.tag == rob_tag_t'(i)),
      .cdb_data (CDB_in.data),
      .clear    (commit_valid && head == rob_tag_t'(i)),
      .q        (ent[i])
    );
  end

  assign head_e       = ent[head];
  assign commit_valid = head_e.valid & head_e.ready;
  assign commit_we    = commit_valid & head_e.has_dest;
  assign commit_reg   = commit_valid ? head_e.dest_reg : '0;
  assign commit_data  = commit_valid ? head_e.value : '0;
  assign commit_tag   = commit_valid ? head : '0;

  assign lookup_rdy_a = ent[lookup_tag_a].valid &
    (ent[lookup_tag_a].ready |
     (CDB_in.valid & (CDB_in.tag == lookup_tag_a)));
  assign lookup_val_a = ent[lookup_tag_a].ready ?
    ent[lookup_tag_a].value : CDB_in.data;

  assign lookup_rdy_b = ent[lookup_tag_b].valid &
    (ent[lookup_tag_b].ready |
     (CDB_in.valid & (CDB_in.tag == lookup_tag_b)));
  assign lookup_val_b = ent[lookup_tag_b].ready ?
    ent[lookup_tag_b].value : CDB_in.data;

  // occupancy: alloc adds, retire removes, both cancel
  always_comb begin
    count_nxt = count;
    unique case ({alloc_ok, commit_valid})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // head/tail/count registers
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (alloc_ok)     tail <= tag_inc(tail);
      if (commit_valid) head <= tag_inc(head);
      count <= count_nxt;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Reorder buffer bench.
// Scoreboard of allocs, checked at each commit.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  cdb_t       cdb;
  logic       alloc_req;
  logic       alloc_has_dest;
  lc3b_reg    alloc_dest_reg;
  logic [2:0] alloc_tag;
  logic       full;
  logic       empty;
  logic [2:0] lookup_tag_a;
  logic       lookup_rdy_a;
  lc3b_word   lookup_val_a;
  logic [2:0] lookup_tag_b;
  logic       lookup_rdy_b;
  lc3b_word   lookup_val_b;
  logic       commit_valid;
  logic       commit_we;
  lc3b_reg    commit_reg;
  lc3b_word   commit_data;
  logic [2:0] commit_tag;

  typedef struct {
    logic [2:0] tag;
    lc3b_reg    rg;
    logic       we;
  } exp_t;

  exp_t     sb [$];
  lc3b_word mval [8];
  int       checks = 0;
  int       errors = 0;

  always #5 clk = ~clk;

  reorder_buffer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .CDB_in         (cdb),
    .alloc_req      (alloc_req),
    .alloc_has_dest (alloc_has_dest),
    .alloc_dest_reg (alloc_dest_reg),
    .alloc_tag      (alloc_tag),
    .full           (full),
    .empty          (empty),
    .lookup_tag_a   (lookup_tag_a),
    .lookup_rdy_a   (lookup_rdy_a),
    .lookup_val_a   (lookup_val_a),
    .lookup_tag_b   (lookup_tag_b),
    .lookup_rdy_b   (lookup_rdy_b),
    .lookup_val_b   (lookup_val_b),
    .commit_valid   (commit_valid),
    .commit_we      (commit_we),
    .commit_reg     (commit_reg),
    .commit_data    (commit_data),
    .commit_tag     (commit_tag)
  );

  task automatic check(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, got, exp);
    end
  endtask

  // commit monitor: pop oldest alloc and compare
  always @(negedge clk) begin
    if (rst_n && commit_valid) begin
      exp_t e;
      if (sb.size() == 0) begin
        check("commit_unexpected", 1, 0);
      end else begin
        e = sb.pop_front();
        check("commit_tag", commit_tag, e.tag);
        check("commit_reg", commit_reg, e.rg);
        check("commit_we", commit_we, e.we);
        check("commit_data", commit_data, mval[e.tag]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_req      = 1'b0;
    alloc_has_dest = 1'b0;
    alloc_dest_reg = '0;
    cdb            = '0;
    flush          = 1'b0;
  endtask

  task automatic drive_cdb(input int t, input lc3b_word d);
    cdb = '{valid: 1'b1, tag: 3'(t), data: d};
    mval[t] = d;
  endtask

  task automatic alloc(input int t, input int r,
                       input logic hd);
    alloc_req      = 1'b1;
    alloc_has_dest = hd;
    alloc_dest_reg = 3'(r);
    @(negedge clk);
    check("alloc_tag", alloc_tag, t);
    check("alloc_not_full", full, 0);
    sb.push_back('{tag: 3'(t), rg: 3'(r), we: hd});
    tick();
    alloc_req = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    sb.delete();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain", sb.size(), 0);
  endtask

  initial begin
    idle();
    lookup_tag_a = '0;
    lookup_tag_b = '0;
    for (int i = 0; i < 8; i++) mval[i] = '0;
    rst_n = 1'b0;
    tick();
    tick();
    @(negedge clk);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_commit_valid", commit_valid, 0);
    check("rst_commit_we", commit_we, 0);
    check("rst_commit_data", commit_data, 0);
    check("rst_lookup_rdy", lookup_rdy_a, 0);
    check("rst_alloc_tag", alloc_tag, 0);
    rst_n = 1'b1;
    tick();

    // fill all eight slots
    for (int i = 0; i < 8; i++) alloc(i, i, 1'b1);
    @(negedge clk);
    check("t1_full", full, 1);
    check("t1_empty", empty, 0);
    tick();
    alloc_req = 1'b1;
    @(negedge clk);
    check("t1_9th_tag", alloc_tag, 0);
    tick();
    alloc_req = 1'b0;
    @(negedge clk);
    check("t1_tail_hold", alloc_tag, 0);
    check("t1_still_full", full, 1);
    tick();
    do_flush();
    @(negedge clk);
    check("t1_flush_empty", empty, 1);
    tick();

    // out-of-order completion, in-order retire
    alloc(0, 1, 1'b1);
    alloc(1, 2, 1'b1);
    alloc(2, 3, 1'b1);
    drive_cdb(2, 16'h0030);
    @(negedge clk);
    check("t2_cv_a", commit_valid, 0);
    tick();
    drive_cdb(0, 16'h0010);
    @(negedge clk);
    check("t2_cv_same_cycle", commit_valid, 0);
    tick();
    drive_cdb(1, 16'h0020);
    @(negedge clk);
    check("t2_cv0", commit_valid, 1);
    check("t2_tag0", commit_tag, 0);
    tick();
    cdb = '0;
    @(negedge clk);
    check("t2_cv1", commit_valid, 1);
    check("t2_tag1", commit_tag, 1);
    tick();
    @(negedge clk);
    check("t2_cv2", commit_valid, 1);
    check("t2_tag2", commit_tag, 2);
    tick();
    drain(4);
    @(negedge clk);
    check("t2_empty", empty, 1);
    tick();

    // same-cycle CDB bypass on lookup
    alloc(3, 5, 1'b1);
    alloc(4, 6, 1'b1);
    lookup_tag_a = 3'd4;
    lookup_tag_b = 3'd3;
    @(negedge clk);
    check("t3_rdy_a_before", lookup_rdy_a, 0);
    tick();
    drive_cdb(4, 16'hBEEF);
    @(negedge clk);
    check("t3_rdy_a", lookup_rdy_a, 1);
    check("t3_val_a", lookup_val_a, 16'hBEEF);
    check("t3_rdy_b", lookup_rdy_b, 0);
    tick();
    cdb = '0;
    @(negedge clk);
    check("t3_rdy_a_held", lookup_rdy_a, 1);
    check("t3_val_a_held", lookup_val_a, 16'hBEEF);
    check("t3_cv_head_wait", commit_valid, 0);
    tick();
    drive_cdb(3, 16'h3333);
    @(negedge clk);
    check("t3_rdy_b", lookup_rdy_b, 1);
    check("t3_val_b", lookup_val_b, 16'h3333);
    tick();
    cdb = '0;
    drain(4);

    // wrap with alloc refused while full
    do_flush();
    for (int i = 0; i < 8; i++) alloc(i, i, 1'b1);
    drive_cdb(0, 16'h0100);
    @(negedge clk);
    check("t4_full", full, 1);
    check("t4_cv_wait", commit_valid, 0);
    tick();
    drive_cdb(1, 16'h0101);
    alloc_req      = 1'b1;
    alloc_has_dest = 1'b1;
    alloc_dest_reg = 3'd0;
    @(negedge clk);
    check("t4_cv_full", commit_valid, 1);
    check("t4_full_refuse", full, 1);
    check("t4_refused_tag", alloc_tag, 0);
    tick();
    alloc_req = 1'b0;
    drive_cdb(2, 16'h0102);
    alloc(0, 0, 1'b1);
    drive_cdb(3, 16'h0103);
    alloc(1, 1, 1'b1);
    cdb = '0;
    alloc(2, 2, 1'b1);
    alloc(3, 3, 1'b1);
    @(negedge clk);
    check("t4_refull", full, 1);
    check("t4_tail", alloc_tag, 4);
    check("t4_cv_end", commit_valid, 0);
    tick();
    do_flush();

    // flush mid-flight beats CDB and alloc
    for (int i = 0; i < 5; i++) alloc(i, i + 1, 1'b1);
    drive_cdb(1, 16'h0011);
    @(negedge clk);
    tick();
    drive_cdb(3, 16'h0033);
    @(negedge clk);
    check("t5_cv_pre", commit_valid, 0);
    tick();
    drive_cdb(2, 16'h0022);
    alloc_req = 1'b1;
    flush     = 1'b1;
    @(negedge clk);
    check("t5_cv_flush", commit_valid, 0);
    tick();
    idle();
    sb.delete();
    lookup_tag_a = 3'd1;
    @(negedge clk);
    check("t5_empty", empty, 1);
    check("t5_full", full, 0);
    check("t5_cv", commit_valid, 0);
    check("t5_alloc_tag", alloc_tag, 0);
    check("t5_lookup", lookup_rdy_a, 0);
    tick();

    // no-dest entry still retires
    alloc(0, 7, 1'b0);
    drive_cdb(0, 16'h5A5A);
    @(negedge clk);
    check("t6_cv_wait", commit_valid, 0);
    tick();
    cdb = '0;
    @(negedge clk);
    check("t6_cv", commit_valid, 1);
    check("t6_we", commit_we, 0);
    tick();
    @(negedge clk);
    check("t6_empty", empty, 1);
    check("t6_alloc_tag", alloc_tag, 1);
    tick();
    alloc(1, 4, 1'b1);
    drive_cdb(1, 16'h4444);
    tick();
    cdb = '0;
    drain(4);

    // reset mid-flight drops entries
    alloc(2, 2, 1'b1);
    alloc(3, 3, 1'b1);
    drive_cdb(2, 16'h0202);
    rst_n = 1'b0;
    tick();
    idle();
    sb.delete();
    rst_n = 1'b1;
    @(negedge clk);
    check("rst2_empty", empty, 1);
    check("rst2_cv", commit_valid, 0);
    check("rst2_alloc_tag", alloc_tag, 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
